// File: rtl/overlap_ctrl.sv
// Overlap-add sequencer for the hybrid synthesis stage.
// Adds IMDCT first halves to stored halves and saves the new second halves.
module overlap_ctrl #(
    parameter int DW   = 16,
    parameter int NSB  = 32,
    parameter int HALF = 18,
    parameter int NCH  = 2,
    parameter int AW   = 11,
    parameter int CW   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] ch,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [4:0]    out_sb,
    output logic [4:0]    out_idx
);
    localparam int CH_SZ  = NSB * HALF;
    localparam int MEM_SZ = NCH * CH_SZ;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_ADD, S_STORE, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic          live_q, live_d;
    logic [AW-1:0] clr_q, clr_d;
    logic [CW-1:0] chl_q, chl_d;
    logic [4:0]    sb_q, sb_d;
    logic [4:0]    k_q, k_d;
    logic [4:0]    psb_q, psb_d;
    logic [4:0]    pk_q, pk_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] reg_q, reg_d;
    logic          ov_q, ov_d;
    logic [DW-1:0] od_q, od_d;
    logic [4:0]    osb_q, osb_d;
    logic [4:0]    oidx_q, oidx_d;
    logic          done_q, done_d;

    logic          free;
    logic          accept;
    logic [AW-1:0] addr;
    logic [DW:0]   sum;
    logic [DW-1:0] sat;

    assign busy      = live_q && (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_sb    = osb_q;
    assign out_idx   = oidx_q;

    // Sample address and saturated overlap sum of the pending sample.
    always_comb begin
        addr = AW'(chl_q) * AW'(CH_SZ)
             + AW'(sb_q) * AW'(HALF)
             + AW'(k_q);
        sum = {reg_q[DW-1], reg_q} + {mem_rdata[DW-1], mem_rdata};
        sat = sum[DW-1:0];
        if (sum[DW] != sum[DW-1])
            sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                          : {1'b0, {(DW-1){1'b1}}};
    end

    // Input handshake and memory strobes; idle while held in reset.
    always_comb begin
        free      = !ov_q || out_ready;
        in_ready  = 1'b0;
        if (live_q) begin
            unique case (state_q)
                S_ADD:   in_ready = !pend_q && free;
                S_STORE: in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
        accept    = in_valid && in_ready;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        if (live_q && state_q == S_CLEAR) begin
            mem_wr_en = 1'b1;
            mem_addr  = clr_q;
        end else if (accept) begin
            mem_addr  = addr;
            mem_rd_en = (state_q == S_ADD);
            mem_wr_en = (state_q == S_STORE);
            if (state_q == S_STORE)
                mem_wdata = in_data;
        end
    end

    // Sequencer next state, counters and output register.
    always_comb begin
        state_d = state_q;
        live_d  = 1'b1;
        clr_d   = clr_q;
        chl_d   = chl_q;
        sb_d    = sb_q;
        k_d     = k_q;
        psb_d   = psb_q;
        pk_d    = pk_q;
        pend_d  = 1'b0;
        reg_d   = reg_q;
        ov_d    = ov_q;
        od_d    = od_q;
        osb_d   = osb_q;
        oidx_d  = oidx_q;
        done_d  = 1'b0;
        if (ov_q && out_ready)
            ov_d = 1'b0;
        if (pend_q) begin
            ov_d   = 1'b1;
            od_d   = sat;
            osb_d  = psb_q;
            oidx_d = pk_q;
        end
        if (live_q) begin
            unique case (state_q)
                S_CLEAR: begin
                    clr_d = clr_q + 1'b1;
                    if (clr_q == AW'(MEM_SZ - 1)) begin
                        clr_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        chl_d   = ch;
                        sb_d    = '0;
                        k_d     = '0;
                        state_d = S_ADD;
                    end
                end
                S_ADD: begin
                    if (accept) begin
                        pend_d = 1'b1;
                        reg_d  = in_data;
                        psb_d  = sb_q;
                        pk_d   = k_q;
                        k_d    = k_q + 5'd1;
                        if (k_q == 5'(HALF - 1)) begin
                            k_d     = '0;
                            state_d = S_STORE;
                        end
                    end
                end
                S_STORE: begin
                    if (accept) begin
                        k_d = k_q + 5'd1;
                        if (k_q == 5'(HALF - 1)) begin
                            k_d = '0;
                            if (sb_q == 5'(NSB - 1)) begin
                                state_d = S_DRAIN;
                            end else begin
                                sb_d    = sb_q + 5'd1;
                                state_d = S_ADD;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pend_q && free) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_CLEAR;
            endcase
        end
    end

    // State registers; reset restarts the memory clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            live_q  <= 1'b0;
            clr_q   <= '0;
            chl_q   <= '0;
            sb_q    <= '0;
            k_q     <= '0;
            psb_q   <= '0;
            pk_q    <= '0;
            pend_q  <= 1'b0;
            reg_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            osb_q   <= '0;
            oidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            clr_q   <= clr_d;
            chl_q   <= chl_d;
            sb_q    <= sb_d;
            k_q     <= k_d;
            psb_q   <= psb_d;
            pk_q    <= pk_d;
            pend_q  <= pend_d;
            reg_q   <= reg_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            osb_q   <= osb_d;
            oidx_q  <= oidx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_overlap_ctrl.sv
// Directed bench for overlap_ctrl with a behavioural overlap memory.
// Frames use per-parity constant inputs with hand-computed sums.
module tb_overlap_ctrl;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [0:0]         ch;
    logic               busy;
    logic               done;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic [10:0]        mem_addr;
    logic               mem_rd_en;
    logic signed [15:0] mem_rdata;
    logic               mem_wr_en;
    logic signed [15:0] mem_wdata;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [4:0]         out_sb;
    logic [4:0]         out_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int a0, a1, b0, b1;
    logic signed [15:0] mem [2048];

    overlap_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch(ch),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sb(out_sb), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // Single-port memory, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int fval(input int i);
        int sb, k;
        sb = i / 36;
        k  = i % 36;
        if (k < 18) return (sb % 2) ? a1 : a0;
        return (sb % 2) ? b1 : b0;
    endfunction

    task automatic clear_sweep(input string tag);
        int n, good, dn;
        n = 0; good = 0; dn = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (done) dn++;
            if (!busy) break;
            if (mem_wr_en && !mem_rd_en && mem_addr == 11'(n)
                && mem_wdata == 16'sd0) good++;
            n++;
        end
        check({tag, "_cycles"}, n, 1152);
        check({tag, "_writes"}, good, 1152);
        check({tag, "_done"}, dn, 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic run_frame(input string tag, input int chv,
                             input int e0, input int e1,
                             input int hold_at, input bit inj,
                             input int abort_at);
        int icnt, ocnt, rcnt, wcnt, dn, both, hold, base, ex;
        bit held, injd;
        icnt = 0; ocnt = 0; rcnt = 0; wcnt = 0; dn = 0;
        both = 0; hold = 0; held = 0; injd = 0;
        base = chv * 576;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            ch = 1'(chv);
            if (inj && !injd && icnt == 50) begin
                start = 1'b1;
                ch = ~1'(chv);
                injd = 1'b1;
            end
            in_valid = (icnt < 1152);
            in_data = 16'(fval(icnt));
            if (!held && hold_at >= 0 && ocnt == hold_at && out_valid) begin
                held = 1'b1;
                hold = 10;
                out_ready = 1'b0;
            end else if (held && hold == 0) begin
                out_ready = 1'b1;
            end
            #1;
            if (hold > 0) begin
                ex = ((ocnt / 18) % 2) ? e1 : e0;
                check({tag, "_hold_valid"}, int'(out_valid), 1);
                check({tag, "_hold_data"}, out_data, ex);
                check({tag, "_hold_pos"}, {out_sb, out_idx},
                      ((ocnt / 18) << 5) | (ocnt % 18));
                check({tag, "_hold_inrdy"}, int'(in_ready), 0);
                check({tag, "_hold_rd"}, int'(mem_rd_en), 0);
                hold--;
            end
            if (done) dn++;
            if (mem_rd_en && mem_wr_en) both++;
            if (mem_rd_en) begin
                check({tag, "_rd_addr"}, mem_addr, base + rcnt);
                rcnt++;
            end
            if (mem_wr_en) begin
                check({tag, "_wr_addr"}, mem_addr, base + wcnt);
                check({tag, "_wr_data"}, mem_wdata,
                      ((wcnt / 18) % 2) ? b1 : b0);
                wcnt++;
            end
            if (out_valid && out_ready) begin
                ex = ((ocnt / 18) % 2) ? e1 : e0;
                check({tag, "_out_data"}, out_data, ex);
                check({tag, "_out_pos"}, {out_sb, out_idx},
                      ((ocnt / 18) << 5) | (ocnt % 18));
                ocnt++;
            end
            if (in_valid && in_ready) icnt++;
            if (dn > 0) break;
            if (abort_at >= 0 && icnt == abort_at) break;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (abort_at < 0) begin
            check({tag, "_inputs"}, icnt, 1152);
            check({tag, "_outputs"}, ocnt, 576);
            check({tag, "_reads"}, rcnt, 576);
            check({tag, "_writes"}, wcnt, 576);
            check({tag, "_done"}, dn, 1);
            check({tag, "_rw_same"}, both, 0);
            check({tag, "_busy_end"}, int'(busy), 0);
            @(negedge clk); #1;
            check({tag, "_done_once"}, int'(done), 0);
            check({tag, "_ov_end"}, int'(out_valid), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'sh5a5a;
        rst_n = 1'b0;
        start = 1'b0;
        ch = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr", int'(mem_wr_en), 0);
        check("rst_rd", int'(mem_rd_en), 0);
        check("rst_ov", int'(out_valid), 0);
        check("rst_inrdy", int'(in_ready), 0);
        check("rst_outs", {out_data, out_sb, out_idx, mem_addr}, 0);
        rst_n = 1'b1;
        clear_sweep("clr0");

        a0 = 100; a1 = 100; b0 = 100; b1 = 100;
        run_frame("f1", 0, 100, 100, -1, 1'b0, -1);
        a0 = 200; a1 = 200; b0 = 200; b1 = 200;
        run_frame("f2", 0, 300, 300, 100, 1'b0, -1);
        a0 = 5; a1 = 5; b0 = 5; b1 = 5;
        run_frame("f3", 1, 5, 5, -1, 1'b1, -1);
        a0 = 0; a1 = 0; b0 = 30000; b1 = -30000;
        run_frame("f4", 0, 200, 200, -1, 1'b0, -1);
        a0 = 10000; a1 = -10000; b0 = 0; b1 = 0;
        run_frame("f5", 0, 32767, -32768, -1, 1'b0, -1);
        a0 = 1; a1 = 1; b0 = 1; b1 = 1;
        run_frame("f6", 0, 1, 1, -1, 1'b0, 20);

        rst_n = 1'b0;
        #1;
        check("mid_busy", int'(busy), 0);
        check("mid_wr", int'(mem_wr_en), 0);
        check("mid_inrdy", int'(in_ready), 0);
        check("mid_ov", int'(out_valid), 0);
        check("mid_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_sweep("clr1");

        a0 = 7; a1 = 7; b0 = 7; b1 = 7;
        run_frame("f7", 1, 7, 7, -1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/overlap_ctrl.md
Name: overlap_ctrl

Overview:
- Sequencer for the hybrid-synthesis overlap-add stage: consumes one channel's IMDCT output stream (NSB subbands × 2·HALF samples each) and produces NSB × HALF overlapped samples.
- Owns address/enable generation for the single-port overlap memory that holds the previous granule's second halves for every channel.
- Clears that memory after reset.
- Sits between the IMDCT stream source and the downstream polyphase sink.

Parameters:
- DW, 16, signed sample width.
- NSB, 32, subbands per granule.
- HALF, 18, samples per half-block.
- NCH, 2, channels held in overlap memory.
- AW, 11, memory address width; must satisfy 2^AW ≥ NCH·NSB·HALF.
- CW, 1, channel select width, clog2(NCH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame request; ignored while busy=1
- ch  in  CW  channel, sampled when start is accepted
- busy  out  1  high in CLEAR, ADD, STORE, DRAIN
- done  out  1  one-cycle pulse at frame end
- in_valid  in  1  IMDCT sample valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_data  in  DW  IMDCT sample; order sb 0..NSB-1, k 0..2·HALF-1
- mem_addr  out  AW  overlap memory address
- mem_rd_en  out  1  read strobe; data returned next cycle
- mem_rdata  in  DW  read data
- mem_wr_en  out  1  write strobe
- mem_wdata  out  DW  write data
- out_valid  out  1  overlapped sample valid
- out_ready  in  1  downstream ready
- out_data  out  DW  saturated sum
- out_sb  out  5  subband of out_data
- out_idx  out  5  index 0..HALF-1 of out_data

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state CLEAR, counters 0, pending flag 0.
- Release of rst_n enters CLEAR.
- Address formula: addr = chl·NSB·HALF + sb·HALF + k, where k is the position within the current half (0..HALF-1).
- Read and write are never issued in the same cycle.
- CLEAR:
  - mem_wr_en=1 and mem_wdata=0 every cycle; addr walks 0..NCH·NSB·HALF-1 (1152 cycles).
  - busy=1, in_ready=0.
  - Then → IDLE; no done pulse.
- IDLE:
  - busy=0, in_ready=0.
  - start=1 latches ch into chl, sb=0, k=0, → ADD.
- ADD (first half of subband sb):
  - in_ready = !pend & (!out_valid | out_ready).
  - On accept: mem_rd_en=1 at addr(chl,sb,k); in_data registered; pend=1.
  - Next cycle: out_data = sat(reg + mem_rdata), out_sb=sb, out_idx=k; out_valid=1; pend=0.
  - Throughput: at most 1 accept per 2 cycles.
  - Sum is computed DW+1 wide, then clamped to [-2^(DW-1), 2^(DW-1)-1].
  - After the k=HALF-1 accept: k=0, → STORE.
- STORE (second half):
  - in_ready=1 (pend clears automatically).
  - On accept: mem_wr_en=1, mem_wdata=in_data, addr(chl,sb,k); no output.
  - After k=HALF-1: if sb<NSB-1, sb++, → ADD; else → DRAIN.
- DRAIN:
  - in_ready=0.
  - When pend=0 and (out_valid=0 or out_ready=1 this cycle): done=1 for one cycle, → IDLE.
- Output register:
  - Holds value while out_valid & !out_ready.
  - Clears out_valid on handshake unless reloaded in the same cycle.
- start during CLEAR/ADD/STORE/DRAIN: ignored, no effect on chl.
- in_valid with in_ready=0: no memory access, counters unchanged.
- Reset mid-frame: frame abandoned, memory re-cleared, no done pulse.

Test Plan:
- Reset release: exactly 1152 writes of 0 at addr 0..1151 in consecutive cycles, busy=1 throughout, then busy=0, no done.
- start, ch=0, all 1152 inputs = 100, out_ready=1: 576 outputs of 100 with (out_sb,out_idx) in order (0,0)..(31,17); writes of 100 to addr 0..575 only; done pulses once.
- Repeat ch=0 with inputs 200: all outputs 300. Then ch=1 with inputs 5: outputs 5; reads/writes confined to addr 576..1151.
- Saturation: stored 30000 + input 10000 → 32767; stored -30000 + input -10000 → -32768.
- Hold out_ready=0 for 10 cycles mid-ADD: out_data/out_sb/out_idx stable, in_ready=0, mem_rd_en=0; resumes with no lost or duplicate samples.
- start pulsed during ADD: ignored. rst_n low mid-STORE: outputs 0 immediately, full CLEAR sweep follows, no done pulse.
